// File: rtl/tlb_refill_ctrl.sv
// TLB sequencing controller: arbitrates fetch/data translation requests, looks up the TLB
// and refills misses from a single-level page table in memory.
module tlb_refill_ctrl #(
  parameter logic [7:0]  PT_BASE = 8'h80,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ireq,
  input  logic [5:0]  ivaddr,
  output logic        idone,
  input  logic        dreq,
  input  logic [5:0]  dvaddr,
  output logic        ddone,
  output logic [5:0]  paddr,
  output logic        fault,
  output logic [5:0]  tlb_vaddr,
  input  logic        tlb_hit,
  input  logic [5:0]  tlb_paddr,
  input  logic [5:0]  tlb_victim,
  output logic        tlb_we,
  output logic [5:0]  tlb_widx,
  output logic [14:0] tlb_wentry,
  output logic        pt_rd,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rdata,
  input  logic        pt_ack,
  output logic [7:0]  miss_cnt,
  output logic [7:0]  fault_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWalk,
    StRefill,
    StRespond
  } state_e;

  localparam logic       GntI     = 1'b0;
  localparam logic       GntD     = 1'b1;
  localparam logic [8:0] TmoLimit = 9'(TIMEOUT);

  state_e     state_q;
  logic       gnt_q;
  logic       last_grant_q;
  logic [5:0] cur_vaddr_q;
  logic [5:0] victim_q;
  logic [5:0] frame_q;
  logic [7:0] tmo_q;

  logic       grant_d;
  logic [8:0] tmo_inc;
  logic       tmo_expire;
  logic       unused_pte_bit;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_d    = dreq & (~ireq | (last_grant_q == GntI));
    tmo_inc    = {1'b0, tmo_q} + 9'd1;
    tmo_expire = (tmo_inc == TmoLimit);
  end

  // Decoded straight from state so reset removes them asynchronously.
  assign tlb_vaddr = (state_q == StLookup) ? cur_vaddr_q : 6'd0;
  assign pt_rd     = (state_q == StWalk);
  assign pt_addr   = pt_rd ? (PT_BASE + {2'b00, cur_vaddr_q}) : 8'd0;

  assign unused_pte_bit = pt_rdata[6];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      gnt_q        <= GntI;
      last_grant_q <= GntD;
      cur_vaddr_q  <= 6'd0;
      victim_q     <= 6'd0;
      frame_q      <= 6'd0;
      tmo_q        <= 8'd0;
      idone        <= 1'b0;
      ddone        <= 1'b0;
      paddr        <= 6'd0;
      fault        <= 1'b0;
      tlb_we       <= 1'b0;
      tlb_widx     <= 6'd0;
      tlb_wentry   <= 15'd0;
      miss_cnt     <= 8'd0;
      fault_cnt    <= 8'd0;
    end else begin
      idone  <= 1'b0;
      ddone  <= 1'b0;
      tlb_we <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ireq || dreq) begin
            gnt_q       <= grant_d;
            cur_vaddr_q <= grant_d ? dvaddr : ivaddr;
            state_q     <= StLookup;
          end
        end
        StLookup: begin
          if (tlb_hit) begin
            paddr   <= tlb_paddr;
            fault   <= 1'b0;
            idone   <= ~gnt_q;
            ddone   <= gnt_q;
            state_q <= StRespond;
          end else begin
            if (miss_cnt != 8'hFF) begin
              miss_cnt <= miss_cnt + 8'd1;
            end
            victim_q <= tlb_victim;
            tmo_q    <= 8'd0;
            state_q  <= StWalk;
          end
        end
        StWalk: begin
          // An ack on the final wait cycle still beats the timeout.
          if (pt_ack) begin
            if (pt_rdata[7]) begin
              frame_q    <= pt_rdata[5:0];
              tlb_we     <= 1'b1;
              tlb_widx   <= victim_q;
              tlb_wentry <= {1'b1, 1'b0, 1'b1, cur_vaddr_q, pt_rdata[5:0]};
              state_q    <= StRefill;
            end else begin
              paddr   <= 6'd0;
              fault   <= 1'b1;
              idone   <= ~gnt_q;
              ddone   <= gnt_q;
              state_q <= StRespond;
            end
          end else if (tmo_expire) begin
            paddr   <= 6'd0;
            fault   <= 1'b1;
            idone   <= ~gnt_q;
            ddone   <= gnt_q;
            state_q <= StRespond;
          end else begin
            tmo_q <= tmo_inc[7:0];
          end
        end
        StRefill: begin
          paddr   <= frame_q;
          fault   <= 1'b0;
          idone   <= ~gnt_q;
          ddone   <= gnt_q;
          state_q <= StRespond;
        end
        StRespond: begin
          if (fault && (fault_cnt != 8'hFF)) begin
            fault_cnt <= fault_cnt + 8'd1;
          end
          last_grant_q <= gnt_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/tlb_refill_ctrl.md
# tlb_refill_ctrl

Sequencing controller for the processor's 64-entry TLB. It arbitrates translation requests from the instruction-fetch and data-access ports and performs the TLB lookup. On a miss it walks a single-level page table in memory and writes the new entry into the TLB at the victim slot the TLB nominates. It sits between the multicycle control unit's two address sources and the TLB/memory pair.

## Interface
- `PT_BASE`, default 8'h80: byte address of page-table entry 0.
- `TIMEOUT`, default 15: maximum WALK wait cycles before a fault is raised (1..255).
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `ireq` input 1: fetch translation request; held until `idone`.
- `ivaddr` input 6: fetch virtual page; stable while `ireq`=1.
- `idone` output 1: one-cycle completion pulse to fetch.
- `dreq` input 1: data-access request; held until `ddone`.
- `dvaddr` input 6: data virtual page.
- `ddone` output 1: one-cycle completion pulse to data access.
- `paddr` output 6: translated frame, valid only while `idone` or `ddone` is high.
- `fault` output 1: translation failed, valid only while a done signal is high.
- `tlb_vaddr` output 6: lookup tag to the TLB.
- `tlb_hit` input 1: combinational hit flag from the TLB.
- `tlb_paddr` input 6: combinational frame from the TLB.
- `tlb_victim` input 6: index of an invalid or LRU=0 entry.
- `tlb_we` output 1: entry write strobe.
- `tlb_widx` output 6: entry write index.
- `tlb_wentry` output 15: entry written, laid out as {V,D,LRU,TAG[5:0],DATA[5:0]}.
- `pt_rd` output 1: page-table read request; held until `pt_ack`.
- `pt_addr` output 8: page-table entry address.
- `pt_rdata` input 8: PTE, with bit7 = valid and bits[5:0] = frame.
- `pt_ack` input 1: read data valid this cycle.
- `miss_cnt` output 8: saturating count of TLB misses.
- `fault_cnt` output 8: saturating count of faults.

## Operation
- States are IDLE, LOOKUP, WALK, REFILL and RESPOND.
- **IDLE**: if one of `ireq`/`dreq` is high, grant it. If both are high, grant the opposite of `last_grant`. Latch the requester id and its vaddr into `cur_vaddr`, then go to LOOKUP. `last_grant` resets to D, so I wins the first tie.
- **LOOKUP**: drive `tlb_vaddr`=`cur_vaddr` and sample `tlb_hit`.
  - On a hit, latch `tlb_paddr`, set fault=0 and go to RESPOND.
  - On a miss, increment `miss_cnt`, latch `tlb_victim`, clear the timeout counter and go to WALK.
- **WALK**: hold `pt_rd`=1 and `pt_addr`=(`PT_BASE`+`cur_vaddr`) mod 256.
  - On `pt_ack` with `pt_rdata[7]`=1, latch the frame and go to REFILL.
  - On `pt_ack` with `pt_rdata[7]`=0, set fault=1 and go to RESPOND.
  - If the counter reaches `TIMEOUT` with no ack, drop `pt_rd`, set fault=1 and go to RESPOND.
- **REFILL**: one cycle with `tlb_we`=1, `tlb_widx`=latched victim and `tlb_wentry`={1,0,1,`cur_vaddr`,frame}. Set fault=0 and go to RESPOND.
- **RESPOND**: pulse `idone` or `ddone` for the granted requester and drive `paddr`/`fault`. Increment `fault_cnt` if fault=1. Update `last_grant`, then return to IDLE.
- The counters saturate at 8'hFF with no wrap.
- If a requester drops its req mid-transaction, the transaction still completes, including any refill, and done is still pulsed.
- A new request is accepted no earlier than the cycle after RESPOND.
- The controller never issues a second `tlb_we` for the same transaction.

## Timing
- Reset values:
  - state = IDLE.
  - `idone`, `ddone`, `tlb_we`, `pt_rd` and `fault` are 0.
  - `paddr`, `tlb_vaddr`, `tlb_widx`, `tlb_wentry` and `pt_addr` are 0.
  - `miss_cnt`, `fault_cnt` and the timeout counter are 0.
  - `last_grant` = D.
- Reset asserted mid-WALK drops `pt_rd` immediately (asynchronously). Any late `pt_ack` after reset is ignored.
- All outputs are registered except `tlb_vaddr`, `pt_rd` and `pt_addr`, which are decoded from state and latched registers.
- Hit latency: req sampled in cycle 0 (IDLE), LOOKUP in cycle 1, done in cycle 2.
- Miss latency: with `pt_ack` arriving k cycles after WALK entry (k ≥ 0), done comes at cycle 4+k. REFILL is at cycle 3+k.
- Timeout: WALK lasts exactly `TIMEOUT` cycles, then RESPOND follows, so done comes at cycle 2+`TIMEOUT`.
- A `pt_ack` in the same cycle the counter reaches `TIMEOUT` takes priority over the timeout.
- Back-to-back hits from one requester give one done every 3 cycles.

## Test plan
- Single I hit: TLB holds tag 6'h05 → frame 6'h2A; `ireq`=1, `ivaddr`=05 → `idone` in cycle 2, `paddr`=2A, fault=0, `miss_cnt`=0, no `pt_rd`.
- Miss and refill: `dvaddr`=0x10, TLB miss, `tlb_victim`=7, PTE at 0x90 = 8'h9C with ack after 3 cycles → `pt_addr`=0x90, one `tlb_we` with idx 7 and entry {1,0,1,010000,011100}, then `ddone` with `paddr`=1C and `miss_cnt`=1.
- Invalid PTE then timeout: PTE 8'h1C → fault=1. A second request where ack never comes → fault after 15 WALK cycles, no `tlb_we`, `fault_cnt`=2.
- Arbitration: `ireq` and `dreq` held simultaneously on hits → grant order I, D, I, D; each done pulses only its own port.
- Reset mid-WALK plus saturation: assert reset while `pt_rd`=1 → all outputs return to 0 at once and a stray ack is ignored. 300 forced misses → `miss_cnt` ends at 8'hFF.
